// File: rtl/pram_pkg.sv
// pram_pkg - shared widths and types for the PRAM backdoor arbiter.
// The optional dirty tracking is controlled by the PRAM_ARB_DIRTY_EN macro.
package pram_pkg;

  localparam int PRAM_AW = 8;
  localparam int PRAM_DW = 8;

  // Requester identity, also used as the owner field of a read tag.
  typedef enum logic {
    REQ_A = 1'b0,
    REQ_B = 1'b1
  } req_id_e;

  // Read-return tag carried alongside the RTC read latency.
  typedef struct packed {
    logic    valid;
    req_id_e owner;
  } rd_tag_t;

endpackage

// File: rtl/pram_arbiter_if.sv
// pram_arbiter_if - requester A/B handshakes plus the RTC pram port.
// The dirty/dirty_clr pair exists only when PRAM_ARB_DIRTY_EN is defined.
interface pram_arbiter_if;
  import pram_pkg::*;

  logic               a_req;
  logic               a_we;
  logic [PRAM_AW-1:0] a_addr;
  logic [PRAM_DW-1:0] a_wdata;
  logic               a_ack;
  logic [PRAM_DW-1:0] a_rdata;
  logic               a_rvalid;

  logic               b_req;
  logic               b_we;
  logic [PRAM_AW-1:0] b_addr;
  logic [PRAM_DW-1:0] b_wdata;
  logic               b_ack;
  logic [PRAM_DW-1:0] b_rdata;
  logic               b_rvalid;

  logic [PRAM_AW-1:0] pram_a;
  logic [PRAM_DW-1:0] pram_din;
  logic               pram_wr;
  logic [PRAM_DW-1:0] pram_dout;

`ifdef PRAM_ARB_DIRTY_EN
  logic               dirty;
  logic               dirty_clr;

  modport slave (
    input  a_req, a_we, a_addr, a_wdata, b_req, b_we, b_addr, b_wdata, pram_dout, dirty_clr,
    output a_ack, a_rdata, a_rvalid, b_ack, b_rdata, b_rvalid, pram_a, pram_din, pram_wr, dirty
  );
  modport master (
    output a_req, a_we, a_addr, a_wdata, b_req, b_we, b_addr, b_wdata, pram_dout, dirty_clr,
    input  a_ack, a_rdata, a_rvalid, b_ack, b_rdata, b_rvalid, pram_a, pram_din, pram_wr, dirty
  );
`else
  modport slave (
    input  a_req, a_we, a_addr, a_wdata, b_req, b_we, b_addr, b_wdata, pram_dout,
    output a_ack, a_rdata, a_rvalid, b_ack, b_rdata, b_rvalid, pram_a, pram_din, pram_wr
  );
  modport master (
    output a_req, a_we, a_addr, a_wdata, b_req, b_we, b_addr, b_wdata, pram_dout,
    input  a_ack, a_rdata, a_rvalid, b_ack, b_rdata, b_rvalid, pram_a, pram_din, pram_wr
  );
`endif

endinterface

// File: rtl/pram_arbiter_rr_arb2.sv
// rr_arb2 - two-way round-robin arbiter with one-hot grant.
// A lone request wins outright; on a tie the side not served last wins,
// and A wins the first tie after reset.
module rr_arb2 (
  input  logic       clk,
  input  logic       i_rst_n,
  input  logic [1:0] i_req,
  output logic [1:0] o_gnt
);

  logic       r_last_b;
  logic       r_seen;
  logic [1:0] w_gnt;

  // Grant selection; ties alternate once a first grant has been seen.
  always_comb begin
    w_gnt = 2'b00;
    case (i_req)
      2'b01:   w_gnt = 2'b01;
      2'b10:   w_gnt = 2'b10;
      2'b11: begin
        if (r_seen && !r_last_b) begin
          w_gnt = 2'b10;
        end else begin
          w_gnt = 2'b01;
        end
      end
      default: w_gnt = 2'b00;
    endcase
  end

  // Track which requester was served most recently.
  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_last_b <= 1'b0;
      r_seen   <= 1'b0;
    end else if (w_gnt != 2'b00) begin
      r_last_b <= w_gnt[1];
      r_seen   <= 1'b1;
    end else begin
      r_last_b <= r_last_b;
      r_seen   <= r_seen;
    end
  end

  assign o_gnt = w_gnt;

endmodule

// File: rtl/pram_arbiter.sv
// pram_arbiter - shares the RTC PRAM backdoor port between the host image
// channel (A) and the OSD settings channel (B). Registered RTC port, reads
// return RD_LAT (=2) cycles after ack. PRAM_ARB_DIRTY_EN adds B-write tracking.
module pram_arbiter
  import pram_pkg::*;
#(
  parameter int RD_LAT = 2
) (
  input  logic           clk,
  input  logic           reset_n,
  pram_arbiter_if.slave  bus
);

  logic [1:0]         r_rst_sync;
  logic               w_rst_n;
  logic [1:0]         w_req;
  logic [1:0]         w_gnt;
  logic               w_we;
  logic [PRAM_AW-1:0] w_addr;
  logic [PRAM_DW-1:0] w_wdata;
  req_id_e            w_owner;
  rd_tag_t            w_tag_in;
  logic [PRAM_AW-1:0] r_pram_a;
  logic [PRAM_DW-1:0] r_pram_din;
  logic               r_pram_wr;
  rd_tag_t            r_tag [RD_LAT];

  // Reset asserts immediately and releases two clocks after reset_n rises.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rst_sync <= 2'b00;
    end else begin
      r_rst_sync <= {r_rst_sync[0], 1'b1};
    end
  end

  assign w_rst_n = r_rst_sync[1];

  // Requests are ignored while the block is held in reset, keeping acks low.
  assign w_req = {bus.b_req & w_rst_n, bus.a_req & w_rst_n};

  rr_arb2 u_arb (
    .clk     (clk),
    .i_rst_n (w_rst_n),
    .i_req   (w_req),
    .o_gnt   (w_gnt)
  );

  assign bus.a_ack = w_gnt[0];
  assign bus.b_ack = w_gnt[1];

  // Route the winning requester's command towards the RTC port registers.
  always_comb begin
    w_we    = bus.a_we;
    w_addr  = bus.a_addr;
    w_wdata = bus.a_wdata;
    w_owner = REQ_A;
    if (w_gnt[1]) begin
      w_we    = bus.b_we;
      w_addr  = bus.b_addr;
      w_wdata = bus.b_wdata;
      w_owner = REQ_B;
    end else begin
      w_we    = bus.a_we;
      w_addr  = bus.a_addr;
      w_wdata = bus.a_wdata;
      w_owner = REQ_A;
    end
  end

  assign w_tag_in = '{valid: (w_gnt != 2'b00) && !w_we, owner: w_owner};

  // RTC port: load address/data on a grant, strobe write for exactly one cycle.
  always_ff @(posedge clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_pram_a   <= {PRAM_AW{1'b0}};
      r_pram_din <= {PRAM_DW{1'b0}};
      r_pram_wr  <= 1'b0;
    end else if (w_gnt != 2'b00) begin
      r_pram_a   <= w_addr;
      r_pram_din <= w_wdata;
      r_pram_wr  <= w_we;
    end else begin
      r_pram_a   <= r_pram_a;
      r_pram_din <= r_pram_din;
      r_pram_wr  <= 1'b0;
    end
  end

  // Read tags follow the address stage and the RTC's registered dout.
  always_ff @(posedge clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      for (int i = 0; i < RD_LAT; i++) begin
        r_tag[i] <= '{valid: 1'b0, owner: REQ_A};
      end
    end else begin
      r_tag[0] <= w_tag_in;
      for (int i = 1; i < RD_LAT; i++) begin
        r_tag[i] <= r_tag[i-1];
      end
    end
  end

  assign bus.pram_a   = r_pram_a;
  assign bus.pram_din = r_pram_din;
  assign bus.pram_wr  = r_pram_wr;

  assign bus.a_rvalid = r_tag[RD_LAT-1].valid && (r_tag[RD_LAT-1].owner == REQ_A);
  assign bus.b_rvalid = r_tag[RD_LAT-1].valid && (r_tag[RD_LAT-1].owner == REQ_B);
  assign bus.a_rdata  = bus.pram_dout;
  assign bus.b_rdata  = bus.pram_dout;

`ifdef PRAM_ARB_DIRTY_EN
  logic r_dirty;

  // Flag B writes for the host; a write in the same cycle as a clear wins.
  always_ff @(posedge clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_dirty <= 1'b0;
    end else if (w_gnt[1] && bus.b_we) begin
      r_dirty <= 1'b1;
    end else if (bus.dirty_clr) begin
      r_dirty <= 1'b0;
    end else begin
      r_dirty <= r_dirty;
    end
  end

  assign bus.dirty = r_dirty;
`endif

endmodule

// File: tb/tb_pram_arbiter.sv
// tb_pram_arbiter - directed scenarios plus randomized traffic, checked
// every cycle against a transaction-level reference model.
module tb_pram_arbiter;
  import pram_pkg::*;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  pram_arbiter_if bus ();

  pram_arbiter #(.RD_LAT(2)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int n_cmp = 0;
  int n_err = 0;

  function automatic logic [7:0] init_val(int i);
    if (i == 16) return 8'hA5;
    return 8'((i * 37 + 11) & 255);
  endfunction

  // RTC stand-in: registered dout, write takes effect on the edge after pram_wr.
  logic [7:0] rtc_mem [256];
  logic       rtc_ready = 1'b0;
  always @(posedge clk) begin
    if (!rtc_ready) begin
      for (int i = 0; i < 256; i++) rtc_mem[i] <= init_val(i);
      rtc_ready <= 1'b1;
    end else begin
      if (bus.pram_wr) rtc_mem[bus.pram_a] <= bus.pram_din;
      bus.pram_dout <= rtc_mem[bus.pram_a];
    end
  end

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model state
  logic [7:0] ref_mem [256];
  int         m_last;          // -1 none since reset, 0 = A, 1 = B
  logic       e_wr;
  logic [7:0] e_a, e_din;
  logic       p0_v, p0_b, p1_v, p1_b;
  logic [7:0] p0_d, p1_d;
  logic       m_dirty;
  logic       g_a, g_b;        // model grants of the last stepped cycle
  logic       d_a_ack, d_b_ack, d_a_rv;

  task automatic model_reset();
    m_last = -1; e_wr = 1'b0; e_a = 8'h00; e_din = 8'h00;
    p0_v = 1'b0; p0_b = 1'b0; p0_d = 8'h00;
    p1_v = 1'b0; p1_b = 1'b0; p1_d = 8'h00;
    m_dirty = 1'b0; g_a = 1'b0; g_b = 1'b0;
  endtask

  // One clock: check all outputs at the falling edge, then advance the model.
  task automatic step();
    logic       we;
    logic [7:0] ad, wd;
    @(negedge clk);
    g_a = 1'b0; g_b = 1'b0;
    if (bus.a_req && bus.b_req) begin
      if (m_last == 0) g_b = 1'b1; else g_a = 1'b1;
    end else if (bus.a_req) g_a = 1'b1;
    else if (bus.b_req) g_b = 1'b1;
    d_a_ack = bus.a_ack; d_b_ack = bus.b_ack; d_a_rv = bus.a_rvalid;
    chk_eq("a_ack", bus.a_ack, g_a);
    chk_eq("b_ack", bus.b_ack, g_b);
    chk_eq("pram_wr", bus.pram_wr, e_wr);
    chk_eq("pram_a", bus.pram_a, e_a);
    chk_eq("pram_din", bus.pram_din, e_din);
    chk_eq("a_rvalid", bus.a_rvalid, p1_v && !p1_b);
    chk_eq("b_rvalid", bus.b_rvalid, p1_v && p1_b);
    if (p1_v && !p1_b) chk_eq("a_rdata", bus.a_rdata, p1_d);
    if (p1_v && p1_b)  chk_eq("b_rdata", bus.b_rdata, p1_d);
`ifdef PRAM_ARB_DIRTY_EN
    chk_eq("dirty", bus.dirty, m_dirty);
`endif
    p1_v = p0_v; p1_b = p0_b; p1_d = p0_d;
    p0_v = 1'b0;
    e_wr = 1'b0;
    if (g_a || g_b) begin
      we = g_b ? bus.b_we : bus.a_we;
      ad = g_b ? bus.b_addr : bus.a_addr;
      wd = g_b ? bus.b_wdata : bus.a_wdata;
      e_a = ad; e_din = wd;
      if (we) begin
        ref_mem[ad] = wd;
        e_wr = 1'b1;
      end else begin
        p0_v = 1'b1; p0_b = g_b; p0_d = ref_mem[ad];
      end
      m_last = g_b ? 1 : 0;
    end
`ifdef PRAM_ARB_DIRTY_EN
    if (g_b && bus.b_we) m_dirty = 1'b1;
    else if (bus.dirty_clr) m_dirty = 1'b0;
`endif
    @(posedge clk);
    #1;
  endtask

  task automatic chk_idle(input string tag);
    chk_eq({tag, "_a_ack"}, bus.a_ack, 1'b0);
    chk_eq({tag, "_b_ack"}, bus.b_ack, 1'b0);
    chk_eq({tag, "_a_rvalid"}, bus.a_rvalid, 1'b0);
    chk_eq({tag, "_b_rvalid"}, bus.b_rvalid, 1'b0);
    chk_eq({tag, "_pram_a"}, bus.pram_a, 8'h00);
    chk_eq({tag, "_pram_din"}, bus.pram_din, 8'h00);
    chk_eq({tag, "_pram_wr"}, bus.pram_wr, 1'b0);
  endtask

  task automatic set_a(input logic req, input logic we, input logic [7:0] ad, input logic [7:0] wd);
    bus.a_req = req; bus.a_we = we; bus.a_addr = ad; bus.a_wdata = wd;
  endtask

  task automatic set_b(input logic req, input logic we, input logic [7:0] ad, input logic [7:0] wd);
    bus.b_req = req; bus.b_we = we; bus.b_addr = ad; bus.b_wdata = wd;
  endtask

  function automatic logic [7:0] rand_addr();
    if ($urandom_range(0, 3) == 0) return 8'($urandom);
    return 8'($urandom_range(0, 7));
  endfunction

  int cnt_a, cnt_b;

  initial begin
    for (int i = 0; i < 256; i++) ref_mem[i] = init_val(i);
    model_reset();
    reset_n = 1'b0;
    set_a(1'b1, 1'b0, 8'h00, 8'h00);
    set_b(1'b0, 1'b0, 8'h00, 8'h00);
`ifdef PRAM_ARB_DIRTY_EN
    bus.dirty_clr = 1'b0;
`endif
    repeat (3) begin
      @(negedge clk);
      chk_idle("por");
    end
    bus.a_req = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b1;
    repeat (3) step();

    // Continuous dual request: alternate, A first, 4 acks each.
    cnt_a = 0; cnt_b = 0;
    for (int i = 0; i < 8; i++) begin
      set_a(1'b1, 1'b0, 8'(8'h20 + i), 8'h00);
      set_b(1'b1, 1'b0, 8'(8'h40 + i), 8'h00);
      step();
      if (i == 0) chk_eq("t3_first_is_a", d_a_ack, 1'b1);
      cnt_a += int'(d_a_ack); cnt_b += int'(d_b_ack);
    end
    chk_eq("t3_a_acks", cnt_a, 4);
    chk_eq("t3_b_acks", cnt_b, 4);
    set_a(1'b0, 1'b0, 8'h00, 8'h00);
    set_b(1'b0, 1'b0, 8'h00, 8'h00);
    repeat (2) step();

    // A reads 0x10 alone (preloaded 0xA5).
    set_a(1'b1, 1'b0, 8'h10, 8'h00);
    step();
    set_a(1'b0, 1'b0, 8'h00, 8'h00);
    chk_eq("t1_pram_a", bus.pram_a, 8'h10);
    step();
    chk_eq("t1_rvalid", bus.a_rvalid, 1'b1);
    chk_eq("t1_rdata", bus.a_rdata, 8'hA5);
    step();

    // B writes 0x3C to 0xFF, A reads 0xFF the next cycle.
    set_b(1'b1, 1'b1, 8'hFF, 8'h3C);
    step();
    set_b(1'b0, 1'b0, 8'h00, 8'h00);
    set_a(1'b1, 1'b0, 8'hFF, 8'h00);
    chk_eq("t2_wr_high", bus.pram_wr, 1'b1);
    step();
    set_a(1'b0, 1'b0, 8'h00, 8'h00);
    chk_eq("t2_wr_low", bus.pram_wr, 1'b0);
    step();
    chk_eq("t2_rvalid", bus.a_rvalid, 1'b1);
    chk_eq("t2_rdata", bus.a_rdata, 8'h3C);
    step();

    // A back-to-back reads of 0x00..0x03 with B idle.
    cnt_a = 0;
    for (int i = 0; i < 4; i++) begin
      set_a(1'b1, 1'b0, 8'(i), 8'h00);
      step();
      chk_eq("t4_ack", d_a_ack, 1'b1);
      cnt_a += int'(d_a_rv);
    end
    set_a(1'b0, 1'b0, 8'h00, 8'h00);
    repeat (3) begin
      step();
      cnt_a += int'(d_a_rv);
    end
    chk_eq("t4_rvalids", cnt_a, 4);

`ifdef PRAM_ARB_DIRTY_EN
    // B write then clear: 0 -> 1 -> 0.
    chk_eq("d1_pre", bus.dirty, 1'b0);
    set_b(1'b1, 1'b1, 8'h30, 8'h77);
    step();
    set_b(1'b0, 1'b0, 8'h00, 8'h00);
    chk_eq("d1_set", bus.dirty, 1'b1);
    bus.dirty_clr = 1'b1;
    step();
    bus.dirty_clr = 1'b0;
    chk_eq("d1_clr", bus.dirty, 1'b0);
    // B write and clear together: set wins.
    set_b(1'b1, 1'b1, 8'h31, 8'h55);
    bus.dirty_clr = 1'b1;
    step();
    set_b(1'b0, 1'b0, 8'h00, 8'h00);
    bus.dirty_clr = 1'b1;
    chk_eq("d2_set_wins", bus.dirty, 1'b1);
    step();
    bus.dirty_clr = 1'b0;
    // A write leaves dirty clear.
    set_a(1'b1, 1'b1, 8'h32, 8'h11);
    step();
    set_a(1'b0, 1'b0, 8'h00, 8'h00);
    chk_eq("d3_a_write", bus.dirty, 1'b0);
    step();
`endif

    // Reset one cycle after a read ack: read is discarded.
    set_a(1'b1, 1'b0, 8'h05, 8'h00);
    step();
    reset_n = 1'b0;
    set_a(1'b1, 1'b0, 8'h06, 8'h00);
    repeat (3) begin
      @(negedge clk);
      chk_idle("mid_rst");
    end
    set_a(1'b0, 1'b0, 8'h00, 8'h00);
    @(posedge clk); #1;
    reset_n = 1'b1;
    model_reset();
    repeat (3) step();

    // Randomized traffic on both requesters.
    for (int n = 0; n < 400; n++) begin
      if (!bus.a_req || g_a) begin
        if ($urandom_range(0, 9) < 6) set_a(1'b1, 1'($urandom_range(0, 1)), rand_addr(), 8'($urandom));
        else set_a(1'b0, 1'b0, 8'h00, 8'h00);
      end
      if (!bus.b_req || g_b) begin
        if ($urandom_range(0, 9) < 6) set_b(1'b1, 1'($urandom_range(0, 1)), rand_addr(), 8'($urandom));
        else set_b(1'b0, 1'b0, 8'h00, 8'h00);
      end
`ifdef PRAM_ARB_DIRTY_EN
      bus.dirty_clr = ($urandom_range(0, 7) == 0);
`endif
      step();
    end
    set_a(1'b0, 1'b0, 8'h00, 8'h00);
    set_b(1'b0, 1'b0, 8'h00, 8'h00);
`ifdef PRAM_ARB_DIRTY_EN
    bus.dirty_clr = 1'b0;
`endif
    repeat (3) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
